// File: rtl/data_sram_if.sv
// Data SRAM request/response bundle between the CPU (master) and the memory-side responder (slave).
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                    input  data_sram_rdata);
    modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
                    output data_sram_rdata);
endinterface

// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-lane RAM plus an MMIO window (LED, NUM, SWITCH, TIMER), 1-cycle registered read.
// Optional free-running timer register enabled by defining RESPONDER_TIMER_EN.
module data_sram_responder #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [15:0] MMIO_BASE  = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    data_sram_if.slave  sram,
    input  logic [7:0]  switch_in,
    output logic [15:0] led,
    output logic [31:0] num_data
);
    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_NUM   = 16'hF010;
    localparam logic [15:0] OFF_SW    = 16'hF020;
    localparam logic [15:0] OFF_TIMER = 16'hE000;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0]           off;
    logic                  is_mmio;
    logic                  wr;
    logic [31:0]           mmio_rd;
    logic [31:0]           led_merged;
    logic [31:0]           num_merged;
    logic                  unused_addr;

    assign idx         = sram.data_sram_addr[ADDR_WIDTH+1:2];
    assign off         = sram.data_sram_addr[15:0];
    assign is_mmio     = (sram.data_sram_addr[31:16] == MMIO_BASE);
    assign wr          = sram.data_sram_en && (sram.data_sram_wen != 4'b0);
    assign unused_addr = ^sram.data_sram_addr[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [3:0] wen);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    assign led_merged = merge({16'h0, led}, sram.data_sram_wdata, sram.data_sram_wen);
    assign num_merged = merge(num_data, sram.data_sram_wdata, sram.data_sram_wen);

`ifdef RESPONDER_TIMER_EN
    logic [31:0] timer;
    logic [31:0] timer_inc;
    logic        timer_wr;

    // Reads report the count taken at the request edge, i.e. the incremented value.
    assign timer_inc = timer + 32'd1;
    assign timer_wr  = wr && is_mmio && (off == OFF_TIMER);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       timer <= '0;
        else if (timer_wr) timer <= merge(timer, sram.data_sram_wdata, sram.data_sram_wen);
        else               timer <= timer_inc;
    end
`endif

    always_comb begin
        mmio_rd = '0;
        case (off)
            OFF_LED:   mmio_rd = {16'h0, led};
            OFF_NUM:   mmio_rd = num_data;
            OFF_SW:    mmio_rd = {24'h0, switch_in};
`ifdef RESPONDER_TIMER_EN
            OFF_TIMER: mmio_rd = timer_inc;
`endif
            default:   mmio_rd = '0;
        endcase
    end

    // RAM array is never reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && wr && !is_mmio)
            for (int i = 0; i < 4; i++)
                if (sram.data_sram_wen[i]) mem[idx][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram.data_sram_rdata <= '0;
            led                  <= '0;
            num_data             <= '0;
        end else if (sram.data_sram_en) begin
            sram.data_sram_rdata <= is_mmio ? mmio_rd : mem[idx];
            if (wr && is_mmio && off == OFF_LED) led      <= led_merged[15:0];
            if (wr && is_mmio && off == OFF_NUM) num_data <= num_merged;
        end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_data_sram_responder;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  switch_in = 8'h00;
    logic [15:0] led;
    logic [31:0] num_data;
    int          checks = 0;
    int          failures = 0;

    data_sram_if sram();

    data_sram_responder dut (
        .clk(clk), .resetn(resetn), .sram(sram.slave),
        .switch_in(switch_in), .led(led), .num_data(num_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: sparse word map for RAM, plain registers for MMIO.
    logic [31:0] ram_m [int];
    logic [15:0] m_led = 16'h0;
    logic [31:0] m_num = 32'h0;

    task automatic model_rd(input logic [31:0] addr, output logic [31:0] v, output bit known);
        v = 32'h0; known = 1'b1;
        if (addr[31:16] == 16'hBFAF) begin
            case (addr[15:0])
                16'hF000: v = {16'h0, m_led};
                16'hF010: v = m_num;
                16'hF020: v = {24'h0, switch_in};
                16'hE000: known = 1'b0;
                default:  v = 32'h0;
            endcase
        end else if (ram_m.exists(int'(addr[15:2]))) v = ram_m[int'(addr[15:2])];
        else known = 1'b0;
    endtask

    task automatic model_wr(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] old;
        bit          k;
        if (wen == 4'h0) return;
        if (addr[31:16] == 16'hBFAF) begin
            if (addr[15:0] != 16'hF000 && addr[15:0] != 16'hF010) return;
        end
        model_rd(addr, old, k);
        if (!k) old = 32'h0;
        for (int i = 0; i < 4; i++)
            if (wen[i]) old[8*i +: 8] = wdata[8*i +: 8];
        if (addr[31:16] != 16'hBFAF) begin
            if (wen == 4'hF || k) ram_m[int'(addr[15:2])] = old;
        end else if (addr[15:0] == 16'hF000) m_led = old[15:0];
        else m_num = old;
    endtask

    // One request: drive now (just after an edge), take the edge, return model's expected rdata.
    task automatic req(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] exp, output bit known);
        model_rd(addr, exp, known);
        sram.data_sram_en = 1'b1; sram.data_sram_wen = wen;
        sram.data_sram_addr = addr; sram.data_sram_wdata = wdata;
        @(posedge clk); #1;
        model_wr(wen, addr, wdata);
        sram.data_sram_en = 1'b0; sram.data_sram_wen = 4'h0;
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (sram.data_sram_rdata !== 32'h0 || led !== 16'h0 || num_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: rdata=%h led=%h num=%h required all 0", sram.data_sram_rdata, led, num_data);
        end
        #9 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ram_basic;
        logic [31:0] e; bit k;
        req(4'hF, 32'h0000_0010, 32'hDEADBEEF, e, k);
        req(4'hF, 32'h0000_0010, 32'h12345678, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_returns_old: got %h want %h", sram.data_sram_rdata, 32'hDEADBEEF);
        end
        req(4'h0, 32'h0000_0010, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h12345678) begin
            failures++; $display("FAIL ram_read: got %h want %h", sram.data_sram_rdata, 32'h12345678);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] e; bit k;
        req(4'b0010, 32'h0000_0010, 32'hAABBCCDD, e, k);
        req(4'h0, 32'h0000_0010, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h1234CC78) begin
            failures++; $display("FAIL byte_lane: got %h want %h", sram.data_sram_rdata, 32'h1234CC78);
        end
        // Upper address bits alias onto the same word.
        req(4'h0, 32'h7A00_0010, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h1234CC78) begin
            failures++; $display("FAIL alias_read: got %h want %h", sram.data_sram_rdata, 32'h1234CC78);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e; bit k;
        req(4'hF, 32'h0000_0100, 32'h0000_0001, e, k);
        req(4'h0, 32'h0000_0100, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h1) begin
            failures++; $display("FAIL b2b_read: got %h want %h", sram.data_sram_rdata, 32'h1);
        end
        req(4'hF, 32'h0000_0200, 32'h5555AAAA, e, k);
        req(4'hF, 32'h0000_0200, 32'h0BADF00D, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h5555AAAA) begin
            failures++; $display("FAIL rdw_old: got %h want %h", sram.data_sram_rdata, 32'h5555AAAA);
        end
        // Idle cycles hold rdata.
        repeat (2) @(posedge clk); #1;
        checks++;
        if (sram.data_sram_rdata !== 32'h5555AAAA) begin
            failures++; $display("FAIL idle_hold: got %h want %h", sram.data_sram_rdata, 32'h5555AAAA);
        end
    endtask

    task automatic test_mmio;
        logic [31:0] e; bit k;
        req(4'hF, 32'hBFAF_F000, 32'hFFFF_00A5, e, k);
        checks++;
        if (led !== 16'h00A5) begin
            failures++; $display("FAIL led_write: got %h want %h", led, 16'h00A5);
        end
        req(4'h0, 32'hBFAF_F000, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h0000_00A5) begin
            failures++; $display("FAIL led_read: got %h want %h", sram.data_sram_rdata, 32'h0000_00A5);
        end
        switch_in = 8'h3C;
        req(4'h0, 32'hBFAF_F020, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h0000_003C) begin
            failures++; $display("FAIL switch_read: got %h want %h", sram.data_sram_rdata, 32'h0000_003C);
        end
        req(4'h0, 32'hBFAF_F100, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'h0) begin
            failures++; $display("FAIL unmapped_read: got %h want 0", sram.data_sram_rdata);
        end
        req(4'b0101, 32'hBFAF_F010, 32'h11223344, e, k);
        checks++;
        if (num_data !== 32'h00220044) begin
            failures++; $display("FAIL num_lanes: got %h want %h", num_data, 32'h00220044);
        end
    endtask

    task automatic test_timer;
        logic [31:0] e; bit k;
        logic [31:0] w1, w2;
`ifdef RESPONDER_TIMER_EN
        w1 = 32'hFFFF_FFFF; w2 = 32'h0;
`else
        w1 = 32'h0; w2 = 32'h0;
`endif
        req(4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, e, k);
        req(4'h0, 32'hBFAF_E000, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== w1) begin
            failures++; $display("FAIL timer_read1: got %h want %h", sram.data_sram_rdata, w1);
        end
        req(4'h0, 32'hBFAF_E000, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== w2) begin
            failures++; $display("FAIL timer_read2: got %h want %h", sram.data_sram_rdata, w2);
        end
    endtask

    task automatic test_random;
        logic [31:0] e, a, wd;
        logic [3:0]  wen;
        bit          k;
        logic [15:0] offs [4];
        offs[0] = 16'hF000; offs[1] = 16'hF010; offs[2] = 16'hF020; offs[3] = 16'hF030;
        for (int i = 0; i < 16; i++) req(4'hF, i << 2, $urandom, e, k);
        for (int n = 0; n < 300; n++) begin
            switch_in = 8'($urandom);
            wen = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            wd  = $urandom;
            if ($urandom_range(0, 8) < 6) begin
                a = {16'($urandom_range(0, 16'hBFAE)), 10'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
                a[15:6] = 10'h0;
            end else a = {16'hBFAF, offs[$urandom_range(0, 3)]};
            req(wen, a, wd, e, k);
            if (k) begin
                checks++;
                if (sram.data_sram_rdata !== e) begin
                    failures++; $display("FAIL rand_rdata[%0d]: addr=%h got %h want %h", n, a, sram.data_sram_rdata, e);
                end
            end
            checks++;
            if (led !== m_led || num_data !== m_num) begin
                failures++; $display("FAIL rand_regs[%0d]: led=%h num=%h want led=%h num=%h", n, led, num_data, m_led, m_num);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e; bit k;
        req(4'hF, 32'h0000_0040, 32'hCAFEF00D, e, k);
        req(4'hF, 32'hBFAF_F000, 32'h0000_1234, e, k);
        req(4'hF, 32'hBFAF_F010, 32'h8765_4321, e, k);
        resetn = 1'b0;
        #1;
        checks++;
        if (led !== 16'h0 || num_data !== 32'h0 || sram.data_sram_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_async: led=%h num=%h rdata=%h required all 0", led, num_data, sram.data_sram_rdata);
        end
        m_led = 16'h0; m_num = 32'h0;
        // Write held across an edge while in reset must be dropped.
        sram.data_sram_en = 1'b1; sram.data_sram_wen = 4'hF;
        sram.data_sram_addr = 32'h0000_0040; sram.data_sram_wdata = 32'h0;
        @(posedge clk); #1;
        sram.data_sram_en = 1'b0; sram.data_sram_wen = 4'h0;
        resetn = 1'b1;
        req(4'h0, 32'h0000_0040, 32'h0, e, k);
        checks++;
        if (sram.data_sram_rdata !== 32'hCAFEF00D) begin
            failures++; $display("FAIL ram_after_reset: got %h want %h", sram.data_sram_rdata, 32'hCAFEF00D);
        end
    endtask

    initial begin
        sram.data_sram_en = 1'b0; sram.data_sram_wen = 4'h0;
        sram.data_sram_addr = 32'h0; sram.data_sram_wdata = 32'h0;
        test_reset;
        test_ram_basic;
        test_byte_lanes;
        test_back_to_back;
        test_mmio;
        test_timer;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
